// File: rtl/mem_ctrl.sv
// Handshaked load/store controller driving a big-endian byte-lane SRAM port with fixed wait states.
// One request in flight; misaligned or illegal-width requests are answered with an error.
module mem_ctrl #(
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned WAIT_CYCLES = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [ADDR_W-1:0]     req_addr,
    input  logic [3:0]            req_width,
    input  logic                  req_signed,
    input  logic [DATA_W-1:0]     req_data,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [DATA_W-1:0]     resp_data,
    output logic                  resp_err,
    output logic                  sram_ce,
    output logic                  sram_we,
    output logic [ADDR_W-1:0]     sram_addr,
    output logic [DATA_W/8-1:0]   sram_sel,
    output logic [DATA_W-1:0]     sram_data_o,
    input  logic [DATA_W-1:0]     sram_data_i
);

    localparam int unsigned LANES = DATA_W / 8;
    localparam int unsigned OFF_W = $clog2(LANES);

    typedef enum logic [1:0] {StIdle, StAccess, StResp} state_e;

    state_e              state_q, state_d;
    logic [3:0]          cnt_q, cnt_d;
    logic                we_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [3:0]          width_q;
    logic                signed_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [DATA_W-1:0]   resp_data_q, resp_data_d;
    logic                resp_err_q, resp_err_d;
    logic                capture;

    logic                width_ok;
    logic                align_ok;
    logic                req_legal;
    logic [LANES-1:0]    sel;
    logic [DATA_W-1:0]   wdata_rep;
    logic [DATA_W-1:0]   load_val;
    logic                sign_bit;
    logic                in_access;

    // Legality check on the live request inputs.
    always_comb begin
        width_ok  = ((req_width == 4'd1) || (req_width == 4'd2) ||
                     (req_width == 4'd4) || (req_width == 4'd8)) &&
                    (32'(req_width) <= LANES);
        align_ok  = (req_addr[3:0] & (req_width - 4'd1)) == 4'd0;
        req_legal = width_ok && align_ok;
    end

    // Lane select, store replication and load extraction from the registered request.
    always_comb begin
        int unsigned k;
        int unsigned w;
        k         = 32'(addr_q[OFF_W-1:0]);
        w         = 32'(width_q);
        sel       = '0;
        wdata_rep = '0;
        load_val  = '0;
        sign_bit  = sram_data_i[DATA_W-1-8*k];
        for (int unsigned j = 0; j < LANES; j++) begin
            if ((j >= k) && (j < k + w)) begin
                sel[LANES-1-j] = 1'b1;
            end
            // Offset j carries field byte (w-1 - j mod w), counting from the LSB.
            wdata_rep[DATA_W-1-8*j -: 8] =
                wdata_q[8*(((w - 1) - (j & (w - 1))) & (LANES - 1)) +: 8];
        end
        for (int unsigned i = 0; i < LANES; i++) begin
            if (i < w) begin
                load_val[8*i +: 8] = sram_data_i[DATA_W-1-8*((k + w - 1 - i) & (LANES - 1)) -: 8];
            end else begin
                load_val[8*i +: 8] = {8{signed_q & sign_bit}};
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        resp_data_d = resp_data_q;
        resp_err_d  = resp_err_q;
        capture     = 1'b0;
        case (state_q)
            StIdle: begin
                if (req_valid) begin
                    capture     = 1'b1;
                    resp_data_d = '0;
                    if (req_legal) begin
                        state_d    = StAccess;
                        cnt_d      = 4'(WAIT_CYCLES - 1);
                        resp_err_d = 1'b0;
                    end else begin
                        state_d    = StResp;
                        resp_err_d = 1'b1;
                    end
                end
            end
            StAccess: begin
                if (cnt_q == 4'd0) begin
                    state_d     = StResp;
                    resp_data_d = we_q ? '0 : load_val;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            StResp: begin
                if (resp_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            width_q     <= '0;
            signed_q    <= 1'b0;
            wdata_q     <= '0;
            resp_data_q <= '0;
            resp_err_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            resp_data_q <= resp_data_d;
            resp_err_q  <= resp_err_d;
            if (capture) begin
                we_q     <= req_we;
                addr_q   <= req_addr;
                width_q  <= req_width;
                signed_q <= req_signed;
                wdata_q  <= req_data;
            end
        end
    end

    always_comb begin
        in_access   = (state_q == StAccess);
        req_ready   = (state_q == StIdle);
        resp_valid  = (state_q == StResp);
        resp_data   = resp_valid ? resp_data_q : '0;
        resp_err    = resp_valid & resp_err_q;
        sram_ce     = in_access;
        sram_we     = in_access & we_q;
        sram_addr   = in_access ? addr_q : '0;
        sram_sel    = in_access ? sel : '0;
        sram_data_o = (in_access && we_q) ? wdata_rep : '0;
    end

endmodule

// File: doc/mem_ctrl.md
Name: mem_ctrl

Overview:
Parametrised, handshaked load/store controller between the pipeline memory stage and an SRAM port with fixed wait states. It accepts one request at a time and drives a big-endian byte-lane SRAM access lasting WAIT_CYCLES cycles. It returns zero- or sign-extended load data, or a store completion. Misaligned or illegal-width requests get an error response and never reach the SRAM.

Parameters:
ADDR_W  32  address width
DATA_W  32  data width; multiple of 8, power of two (32 or 64)
WAIT_CYCLES  1  cycles sram_ce is held per access; range 1..15

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
req_valid  in  1  request present
req_ready  out  1  controller can accept a request
req_we  in  1  1 = store, 0 = load
req_addr  in  ADDR_W  byte address
req_width  in  4  access size in bytes (1, 2, 4, 8)
req_signed  in  1  sign-extend load data
req_data  in  DATA_W  store data, right-aligned
resp_valid  out  1  response present
resp_ready  in  1  consumer accepts response
resp_data  out  DATA_W  load result (zero for stores and errors)
resp_err  out  1  request rejected (misaligned or illegal width)
sram_ce  out  1  SRAM chip enable
sram_we  out  1  SRAM write enable
sram_addr  out  ADDR_W  SRAM address (full byte address, passed through)
sram_sel  out  DATA_W/8  byte-lane select, MSB lane = byte offset 0
sram_data_o  out  DATA_W  write data to SRAM
sram_data_i  in  DATA_W  read data from SRAM

Behaviour:
- Reset: state IDLE; all outputs 0 except req_ready=1. Reset is honoured mid-access: the access is abandoned, sram_ce drops on the next edge, and no response is produced.
- Let LANES=DATA_W/8 and k = req_addr mod LANES.
- Legal: req_width in {1,2,4,8}, req_width <= LANES, and req_addr mod req_width == 0. Anything else is an error.
- Lane mapping (big-endian): byte offset j uses bits [DATA_W-1-8j -: 8] and sram_sel bit LANES-1-j.
- States: IDLE, ACCESS, RESP.
- IDLE:
  - req_ready=1.
  - Accept occurs on an edge with req_valid=1; all request fields are registered at that edge.
  - Legal request -> ACCESS, counter=WAIT_CYCLES-1.
  - Error request -> RESP with resp_err=1 and resp_data=0. No SRAM cycle is issued.
- ACCESS:
  - req_ready=0; sram_ce=1; sram_we=registered we; sram_addr=registered address.
  - sram_sel has req_width bits set at offsets k..k+width-1. This applies to loads and stores.
  - Store: sram_data_o = low 8*width bits of req_data replicated LANES/width times.
  - Load: sram_data_o=0.
  - The counter decrements each cycle. On the cycle the counter is 0, load data is sampled from sram_data_i and the state moves to RESP.
  - Outside ACCESS, sram_ce, sram_we, sram_sel and sram_data_o are 0.
- Load extraction: the selected width-byte field is right-aligned. Bits above it are filled with the field's MSB if registered signed=1, otherwise 0. For stores, resp_data=0.
- RESP:
  - resp_valid=1; resp_data and resp_err are held stable until resp_ready=1 on an edge, then the state returns to IDLE.
  - req_ready=0 throughout RESP. There is no bypass: a new request is accepted the cycle after the handshake at the earliest.
- Latency for a legal access: accept edge -> WAIT_CYCLES cycles of sram_ce -> resp_valid asserted in the next cycle.
  - Minimum total with WAIT_CYCLES=1 and resp_ready held high: 3 cycles per request.
- Error latency: resp_valid in the cycle after acceptance.
- req_valid may drop while req_ready=0 without effect. Request inputs are ignored outside IDLE.

Test Plan:
- DATA_W=32, WAIT_CYCLES=2: load, addr 0x101, width 1, signed=1, sram_data_i=0x12F45678 -> sram_ce high exactly 2 cycles with sram_sel=0100; resp_data=0xFFFFFFF4; resp_err=0.
- Store, addr 0x102, width 2, req_data=0x0000BEEF -> sram_sel=0011, sram_data_o=0xBEEFBEEF, sram_we=1 for 2 cycles; then resp_valid with resp_data=0.
- Load, addr 0x103, width 4 -> no sram_ce pulse; resp_valid in the next cycle with resp_err=1. Width 3 is rejected the same way.
- Hold resp_ready=0 for 5 cycles after resp_valid -> resp_data stable and req_ready=0. After the handshake, a back-to-back request is accepted the following cycle.
- Assert rst during the 1st ACCESS cycle -> next cycle sram_ce=0, req_ready=1, resp_valid=0, and no response ever appears.
- DATA_W=64: load, addr 0x10, width 8 -> sram_sel=0xFF, resp_data=sram_data_i. Load, addr 0x16, width 2, unsigned, sram_data_i=0x0011223344558899 -> resp_data=0x8899.
